// File: rtl/pc_redirect_control.sv
// Fetch program-counter owner: picks sequential, branch/JAL or JALR targets,
// sequences the post-redirect pipeline flush and traps on misaligned targets.
module pc_redirect_control #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i_l,
  input  logic        ex_valid_w_i_h,
  input  logic        cond_branch_w_i_h,
  input  logic        jal_w_i_h,
  input  logic        jalr_w_i_h,
  input  logic        stall_w_i_h,
  input  logic [31:0] ex_pc_w_i,
  input  logic [31:0] imm_w_i,
  input  logic [31:0] rs1_w_i,
  output logic [31:0] pc_w_o,
  output logic [31:0] link_w_o,
  output logic        flush_w_o_h,
  output logic        misalign_w_o_h,
  output logic [31:0] bad_addr_w_o
);

  typedef enum logic [1:0] {
    RUN,
    TRAP,
    FLUSH
  } state_e;

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] badAddr_q;
  logic [3:0]  flushCnt_q;
  logic        flush_q;
  logic        misalign_q;

  logic        redir;
  logic        misTarget;
  logic [31:0] target;
  logic [31:0] pcSeq;

  // JALR takes priority when several jump flags are set at once.
  always_comb begin
    redir     = ex_valid_w_i_h & (jalr_w_i_h | jal_w_i_h | cond_branch_w_i_h);
    target    = ex_pc_w_i + imm_w_i;
    if (jalr_w_i_h) begin
      target = (rs1_w_i + imm_w_i) & ~32'h1;
    end
    misTarget = |target[1:0];
    pcSeq     = pc_q + 32'd4;
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      badAddr_q  <= 32'h0;
      flushCnt_q <= 4'd0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (redir) begin
            flush_q <= 1'b1;
            if (misTarget) begin
              pc_q       <= TRAP_VECTOR;
              badAddr_q  <= target;
              misalign_q <= 1'b1;
              state_q    <= TRAP;
            end else begin
              pc_q       <= target;
              flushCnt_q <= FlushInit;
              state_q    <= FLUSH;
            end
          end else if (!stall_w_i_h) begin
            pc_q <= pcSeq;
          end
        end
        TRAP: begin
          flushCnt_q <= FlushInit;
          misalign_q <= 1'b0;
          state_q    <= FLUSH;
        end
        FLUSH: begin
          // Redirect inputs here belong to squashed instructions and are ignored.
          if (!stall_w_i_h) begin
            pc_q       <= pcSeq;
            flushCnt_q <= flushCnt_q - 4'd1;
            if (flushCnt_q == 4'd1) begin
              flush_q <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pc_w_o         = pc_q;
  assign link_w_o       = ex_pc_w_i + 32'd4;
  assign flush_w_o_h    = flush_q;
  assign misalign_w_o_h = misalign_q;
  assign bad_addr_w_o   = badAddr_q;

endmodule

// File: tb/tb_pc_redirect_control.sv
// Scoreboard bench for pc_redirect_control: directed vectors push the expected
// post-edge state, and a negedge monitor pops and compares it.
module tb_pc_redirect_control;

  logic        clk_w_i;
  logic        rst_w_i_l;
  logic        ex_valid_w_i_h;
  logic        cond_branch_w_i_h;
  logic        jal_w_i_h;
  logic        jalr_w_i_h;
  logic        stall_w_i_h;
  logic [31:0] ex_pc_w_i;
  logic [31:0] imm_w_i;
  logic [31:0] rs1_w_i;
  logic [31:0] pc_w_o;
  logic [31:0] link_w_o;
  logic        flush_w_o_h;
  logic        misalign_w_o_h;
  logic [31:0] bad_addr_w_o;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [31:0] bad;
  } expT;

  expT expQ[$];
  int  vectorsApplied = 0;
  int  miscompares    = 0;

  pc_redirect_control dut (
    .clk_w_i           (clk_w_i),
    .rst_w_i_l         (rst_w_i_l),
    .ex_valid_w_i_h    (ex_valid_w_i_h),
    .cond_branch_w_i_h (cond_branch_w_i_h),
    .jal_w_i_h         (jal_w_i_h),
    .jalr_w_i_h        (jalr_w_i_h),
    .stall_w_i_h       (stall_w_i_h),
    .ex_pc_w_i         (ex_pc_w_i),
    .imm_w_i           (imm_w_i),
    .rs1_w_i           (rs1_w_i),
    .pc_w_o            (pc_w_o),
    .link_w_o          (link_w_o),
    .flush_w_o_h       (flush_w_o_h),
    .misalign_w_o_h    (misalign_w_o_h),
    .bad_addr_w_o      (bad_addr_w_o)
  );

  initial begin
    clk_w_i = 1'b0;
    forever #5 clk_w_i = ~clk_w_i;
  end

  // Hard time limit so the bench cannot hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout reached before the summary");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input expT e);
    vectorsApplied++;
    if (pc_w_o !== e.pc || flush_w_o_h !== e.flush ||
        misalign_w_o_h !== e.mis || bad_addr_w_o !== e.bad) begin
      miscompares++;
      $display("[TB] FAIL %s: got pc=%h flush=%b mis=%b bad=%h, want pc=%h flush=%b mis=%b bad=%h",
               name, pc_w_o, flush_w_o_h, misalign_w_o_h, bad_addr_w_o,
               e.pc, e.flush, e.mis, e.bad);
    end
  endtask

  task automatic checkLink(input logic [31:0] expLink);
    vectorsApplied++;
    if (link_w_o !== expLink) begin
      miscompares++;
      $display("[TB] FAIL link: got %h, want %h", link_w_o, expLink);
    end
  endtask

  // The monitor consumes one expected record per cycle, away from the active edge.
  always @(negedge clk_w_i) begin
    if (expQ.size() > 0) begin
      checkOutput("vector", expQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic v, input logic cb, input logic jal,
                               input logic jalr, input logic stall,
                               input logic [31:0] exPc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] ePc,
                               input logic eFlush, input logic eMis,
                               input logic [31:0] eBad);
    expT e;
    ex_valid_w_i_h    = v;
    cond_branch_w_i_h = cb;
    jal_w_i_h         = jal;
    jalr_w_i_h        = jalr;
    stall_w_i_h       = stall;
    ex_pc_w_i         = exPc;
    imm_w_i           = imm;
    rs1_w_i           = rs1;
    #1;
    checkLink(exPc + 32'd4);
    @(posedge clk_w_i);
    #1;
    e.pc    = ePc;
    e.flush = eFlush;
    e.mis   = eMis;
    e.bad   = eBad;
    expQ.push_back(e);
  endtask

  task automatic idle(input logic [31:0] ePc, input logic eFlush,
                      input logic eMis, input logic [31:0] eBad);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, ePc, eFlush, eMis, eBad);
  endtask

  initial begin
    expT r;
    rst_w_i_l         = 1'b0;
    ex_valid_w_i_h    = 1'b0;
    cond_branch_w_i_h = 1'b0;
    jal_w_i_h         = 1'b0;
    jalr_w_i_h        = 1'b0;
    stall_w_i_h       = 1'b0;
    ex_pc_w_i         = 32'h0;
    imm_w_i           = 32'h0;
    rs1_w_i           = 32'h0;
    repeat (2) @(posedge clk_w_i);
    #1;
    r = '{pc: 32'h0, flush: 1'b0, mis: 1'b0, bad: 32'h0};
    checkOutput("reset", r);
    rst_w_i_l = 1'b1;

    // Sequential fetch after reset.
    idle(32'h4, 0, 0, 32'h0);
    idle(32'h8, 0, 0, 32'h0);
    idle(32'hC, 0, 0, 32'h0);
    idle(32'h10, 0, 0, 32'h0);

    // Taken branch, then the same branch without ex_valid.
    applyStimulus(1, 1, 0, 0, 0, 32'h40, 32'h20, 32'h0, 32'h60, 1, 0, 32'h0);
    idle(32'h64, 1, 0, 32'h0);
    idle(32'h68, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 32'h40, 32'h20, 32'h0, 32'h6C, 0, 0, 32'h0);
    idle(32'h70, 0, 0, 32'h0);

    // JALR wins over JAL, bit 0 cleared.
    applyStimulus(1, 0, 1, 1, 0, 32'h200, 32'h7, 32'h1001, 32'h1008, 1, 0, 32'h0);
    idle(32'h100C, 1, 0, 32'h0);
    idle(32'h1010, 0, 0, 32'h0);

    // JALR to a halfword address traps.
    applyStimulus(1, 0, 1, 1, 0, 32'h200, 32'h5, 32'h1001, 32'h100, 1, 1, 32'h1006);
    idle(32'h100, 1, 0, 32'h1006);
    idle(32'h104, 1, 0, 32'h1006);
    idle(32'h108, 0, 0, 32'h1006);

    // Redirect under stall, stalled flush, redirect ignored during flush.
    applyStimulus(1, 1, 0, 0, 1, 32'h300, 32'h10, 32'h0, 32'h310, 1, 0, 32'h1006);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h310, 1, 0, 32'h1006);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h310, 1, 0, 32'h1006);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h310, 1, 0, 32'h1006);
    applyStimulus(1, 0, 1, 0, 0, 32'h0, 32'h800, 32'h0, 32'h314, 1, 0, 32'h1006);
    idle(32'h318, 0, 0, 32'h1006);
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h318, 0, 0, 32'h1006);

    // Branch to the last word, sequential step wraps to zero.
    applyStimulus(1, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'hC, 32'h0, 32'hFFFF_FFFC, 1, 0, 32'h1006);
    idle(32'h0, 1, 0, 32'h1006);
    idle(32'h4, 0, 0, 32'h1006);

    // Odd branch target also traps.
    applyStimulus(1, 1, 0, 0, 0, 32'h40, 32'h1, 32'h0, 32'h100, 1, 1, 32'h41);
    idle(32'h100, 1, 0, 32'h41);
    idle(32'h104, 1, 0, 32'h41);
    idle(32'h108, 0, 0, 32'h41);

    // Asynchronous reset in the middle of a flush.
    applyStimulus(1, 1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h20, 1, 0, 32'h41);
    @(negedge clk_w_i);
    #1;
    rst_w_i_l = 1'b0;
    #1;
    r = '{pc: 32'h0, flush: 1'b0, mis: 1'b0, bad: 32'h0};
    checkOutput("async reset", r);
    @(posedge clk_w_i);
    #1;
    rst_w_i_l = 1'b1;
    idle(32'h4, 0, 0, 32'h0);
    idle(32'h8, 0, 0, 32'h0);

    @(negedge clk_w_i);
    #1;
    vectorsApplied++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending records, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_redirect_control.md
Name: pc_redirect_control

Overview:
- Program-counter owner. Consumes `cond_branch_w_o_h` from `cond_branch_control` (as `cond_branch_w_i_h`) plus the jump decode.
- Selects and registers the next fetch PC: sequential, branch/JAL target, or JALR target.
- Sequences a multi-cycle pipeline flush after every taken redirect.
- Raises an instruction-address-misaligned trap for misaligned targets and vectors to `TRAP_VECTOR`.

Parameters:
RESET_VECTOR  32'h0000_0000  PC value loaded on reset
TRAP_VECTOR   32'h0000_0100  PC value loaded on misaligned target
FLUSH_CYCLES  2              cycles `flush_w_o_h` is held after a redirect (legal range 1..15)

Ports:
clk_w_i            input   1   clock, rising edge
rst_w_i_l          input   1   asynchronous active-low reset
ex_valid_w_i_h     input   1   execute stage holds a valid instruction
cond_branch_w_i_h  input   1   conditional branch taken (from `cond_branch_control`)
jal_w_i_h          input   1   execute instruction is JAL
jalr_w_i_h         input   1   execute instruction is JALR
stall_w_i_h        input   1   fetch stall from hazard unit
ex_pc_w_i          input   32  PC of execute-stage instruction
imm_w_i            input   32  sign-extended immediate of execute instruction
rs1_w_i            input   32  rs1 operand (JALR base)
pc_w_o             output  32  current fetch PC (registered)
link_w_o           output  32  ex_pc_w_i + 4, combinational, for rd writeback
flush_w_o_h        output  1   squash IF/ID contents (registered)
misalign_w_o_h     output  1   one-cycle trap pulse (registered)
bad_addr_w_o       output  32  last misaligned target (registered)

Behaviour:
- Clock and reset: one clock, `clk_w_i`. Reset `rst_w_i_l` is asynchronous, active-low; assertion takes effect immediately, independent of the clock.
- Reset values:
  - `pc_w_o` = `RESET_VECTOR`
  - `flush_w_o_h` = 0, `misalign_w_o_h` = 0, `bad_addr_w_o` = 0
  - state = RUN, flush counter = 0
- Reset mid-flush or mid-trap aborts the sequence; RUN is resumed on the first edge after deassertion.
- Redirect request (evaluated in RUN only): `redir = ex_valid_w_i_h & (jalr_w_i_h | jal_w_i_h | cond_branch_w_i_h)`.
- Target priority (simultaneous decode flags resolved deterministically):
  - `jalr_w_i_h`: `target = (rs1_w_i + imm_w_i) & ~32'h1`
  - else `jal_w_i_h` or `cond_branch_w_i_h`: `target = ex_pc_w_i + imm_w_i`
- Arithmetic: all adds are 32-bit, modulo 2^32; wrap-around is silent. Sequential step is `pc_w_o + 4` (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
- Misaligned target: `target[1:0] != 2'b00`. There is no compressed-ISA support, so `target[1]` set is misaligned.
- States:
  - RUN:
    - redir and aligned: `pc <= target`; counter <= `FLUSH_CYCLES`; `flush_w_o_h <= 1`; -> FLUSH.
    - redir and misaligned: `pc <= TRAP_VECTOR`; `bad_addr <= target`; `misalign_w_o_h <= 1`; `flush_w_o_h <= 1`; -> TRAP.
    - no redir, stall high: pc holds.
    - no redir, stall low: `pc <= pc + 4`.
    - A redirect overrides stall.
  - TRAP (exactly 1 cycle):
    - `misalign_w_o_h` is high this cycle only; `flush_w_o_h` stays high.
    - Redirect inputs are ignored.
    - Next edge: counter <= `FLUSH_CYCLES`; `misalign <= 0`; -> FLUSH.
    - pc holds `TRAP_VECTOR` in TRAP.
  - FLUSH:
    - `flush_w_o_h` = 1 throughout.
    - Redirect inputs are ignored; they come from squashed instructions.
    - Stall low: `pc <= pc + 4`; counter decrements.
    - Stall high: pc and counter hold, so the flush stretches.
    - When the counter decrements from 1 to 0: `flush <= 0`; -> RUN on that same edge.
- Latency: redirect decided in cycle t; new `pc_w_o` and `flush_w_o_h` = 1 visible in cycle t+1. With no stall, flush stays high for exactly `FLUSH_CYCLES` cycles.
- `bad_addr_w_o` holds its value until the next misaligned event or reset.
- `link_w_o` is purely combinational and is valid in every state.

Test Plan:
1. Reset then release, stall = 0, no redirect, 4 edges -> `pc_w_o` sequence 0x0, 0x4, 0x8, 0xC, 0x10; `flush_w_o_h` = 0 throughout.
2. Taken branch: `ex_pc` = 0x40, `imm` = 0x20, `cond_branch` = 1, `ex_valid` = 1 -> next cycle `pc` = 0x60, flush high 2 cycles, `pc` 0x64 then 0x68, flush low when `pc` = 0x68. Repeat with `ex_valid` = 0 -> no redirect.
3. JALR with JAL also set: `rs1` = 0x1001, `imm` = 0x7 -> `pc` = 0x1008 (bit 0 cleared, JALR wins); `link_w_o` = `ex_pc` + 4. Same with `imm` = 0x5 -> target 0x1006, misaligned -> `pc` = 0x100, `misalign_w_o_h` pulse 1 cycle, `bad_addr` = 0x1006, flush high 3 cycles total.
4. Redirect with stall = 1 -> `pc` loads target regardless. Stall = 1 for 3 cycles during FLUSH -> `pc` and flush held, flush total 5 cycles. Redirect asserted during FLUSH -> ignored.
5. Wrap: `pc` = 0xFFFF_FFFC via branch target -> next sequential `pc` = 0x0000_0000. Async reset asserted mid-FLUSH -> `pc` = 0x0 and flush = 0 immediately, without a clock edge.
